// File: rtl/fp_addsub_sequencer_pkg.sv
// Shared definitions for the FP add/subtract sequencer: field-width
// defaults and the controller state encoding.
package fp_addsub_sequencer_pkg;

  // Single-precision field widths (the only configuration exercised so far)
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // Controller states; IDLE is zero so a cleared register is a safe state
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_addsub_sequencer_align_shift.sv
// fp_align_shift: combinational right shifter used during ALIGN.
// Bits shifted out are dropped (truncation); a shift of SIG_W or more
// clears the significand entirely.
module fp_align_shift #(
  parameter int SIG_W = 25,
  parameter int SH_W  = 8
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic [SH_W-1:0]  i_shamt,
  output logic [SIG_W-1:0] o_sig
);

  // Large exponent differences leave nothing of the smaller operand
  always_comb begin
    if (32'(i_shamt) >= 32'(SIG_W)) begin
      o_sig = '0;
    end else begin
      o_sig = i_sig >> i_shamt;
    end
  end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// fp_addsub_sequencer: multi-cycle IEEE-754 single add/subtract.
// Sequence: IDLE -> ALIGN -> ADD -> NORM (one shift per cycle) -> DONE.
// Rounding is truncation; zero-exponent inputs are treated as signed zero;
// inf/NaN operands bypass the datapath.
// Optional build macro FP_SEQ_FLAGS_EN adds flag_zero/flag_ovf/flag_unf.
module fp_addsub_sequencer
  import fp_addsub_sequencer_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   busy
`ifdef FP_SEQ_FLAGS_EN
  ,
  output logic                   flag_zero,
  output logic                   flag_ovf,
  output logic                   flag_unf
`endif
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 2;  // carry + hidden + stored mantissa
  localparam logic [EXP_W-1:0] L_EXP_MAX = '1;

  state_t r_state;
  state_t w_state_next;

  // Operand registers; after ALIGN, "a" holds the larger operand and
  // "b" the aligned smaller significand
  logic             r_sign_a, r_sign_b;
  logic [EXP_W-1:0] r_exp_a, r_exp_b;
  logic [SIG_W-1:0] r_sig_a, r_sig_b;
  logic             r_special;

  // Working result during NORM
  logic             r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [SIG_W-1:0] r_sig;
  logic [W-1:0]     r_result;

  // Capture-side decode
  logic             w_sign_a, w_sign_b;
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  logic             w_spec_a, w_spec_b, w_special;
  logic [W-1:0]     w_special_res;

  assign w_sign_a      = op_a[W-1];
  assign w_sign_b      = op_b[W-1] ^ op_sub;
  assign w_exp_a       = op_a[W-2 -: EXP_W];
  assign w_exp_b       = op_b[W-2 -: EXP_W];
  assign w_sig_a       = (w_exp_a == '0) ? '0 : {2'b01, op_a[MAN_W-1:0]};
  assign w_sig_b       = (w_exp_b == '0) ? '0 : {2'b01, op_b[MAN_W-1:0]};
  assign w_spec_a      = (w_exp_a == L_EXP_MAX);
  assign w_spec_b      = (w_exp_b == L_EXP_MAX);
  assign w_special     = w_spec_a | w_spec_b;
  assign w_special_res = w_spec_a ? op_a : {w_sign_b, op_b[W-2:0]};

  // Align-side decode: order by exponent, then by significand
  logic             w_swap;
  logic             w_sign_l, w_sign_s;
  logic [EXP_W-1:0] w_exp_l, w_exp_s, w_diff;
  logic [SIG_W-1:0] w_sig_l, w_sig_s, w_sig_s_sh;

  assign w_swap   = (r_exp_a < r_exp_b) || ((r_exp_a == r_exp_b) && (r_sig_a < r_sig_b));
  assign w_sign_l = w_swap ? r_sign_b : r_sign_a;
  assign w_sign_s = w_swap ? r_sign_a : r_sign_b;
  assign w_exp_l  = w_swap ? r_exp_b  : r_exp_a;
  assign w_exp_s  = w_swap ? r_exp_a  : r_exp_b;
  assign w_sig_l  = w_swap ? r_sig_b  : r_sig_a;
  assign w_sig_s  = w_swap ? r_sig_a  : r_sig_b;
  assign w_diff   = w_exp_l - w_exp_s;

  fp_align_shift #(
    .SIG_W (SIG_W),
    .SH_W  (EXP_W)
  ) u_align_shift (
    .i_sig   (w_sig_s),
    .i_shamt (w_diff),
    .o_sig   (w_sig_s_sh)
  );

  // Magnitude add/subtract; larger-minus-smaller never goes negative
  logic [SIG_W-1:0] w_sum;
  assign w_sum = (r_sign_a == r_sign_b) ? (r_sig_a + r_sig_b) : (r_sig_a - r_sig_b);

  // NORM decode, in priority order: saturate, zero, flush, shift, pack
  logic w_norm_ovf, w_norm_zero, w_norm_unf, w_norm_rsh, w_norm_lsh, w_norm_done;
  assign w_norm_ovf  = (r_exp == L_EXP_MAX);
  assign w_norm_zero = (r_sig == '0);
  assign w_norm_unf  = (r_exp == '0);
  assign w_norm_rsh  = r_sig[SIG_W-1];
  assign w_norm_lsh  = ~r_sig[SIG_W-2];
  assign w_norm_done = w_norm_ovf | w_norm_zero | w_norm_unf | (~w_norm_rsh & ~w_norm_lsh);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; new operands are only looked at in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_next = ST_ALIGN;
      ST_ALIGN: w_state_next = r_special ? ST_DONE : ST_ADD;
      ST_ADD:   w_state_next = ST_NORM;
      ST_NORM:  if (w_norm_done) w_state_next = ST_DONE;
      ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

  // Datapath: capture, align, add, then one normalize step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_exp_a   <= '0;
      r_exp_b   <= '0;
      r_sig_a   <= '0;
      r_sig_b   <= '0;
      r_special <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_sig     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign_a  <= w_sign_a;
            r_sign_b  <= w_sign_b;
            r_exp_a   <= w_exp_a;
            r_exp_b   <= w_exp_b;
            r_sig_a   <= w_sig_a;
            r_sig_b   <= w_sig_b;
            r_special <= w_special;
            if (w_special) r_result <= w_special_res;
          end
        end
        ST_ALIGN: begin
          r_sign_a <= w_sign_l;
          r_exp_a  <= w_exp_l;
          r_sig_a  <= w_sig_l;
          r_sign_b <= w_sign_s;
          r_sig_b  <= w_sig_s_sh;
        end
        ST_ADD: begin
          r_sign <= r_sign_a;
          r_exp  <= r_exp_a;
          r_sig  <= w_sum;
        end
        ST_NORM: begin
          if (w_norm_ovf) begin
            r_result <= {r_sign, L_EXP_MAX, {MAN_W{1'b0}}};
          end else if (w_norm_zero || w_norm_unf) begin
            r_result <= '0;
          end else if (w_norm_rsh) begin
            r_sig <= r_sig >> 1;
            r_exp <= r_exp + 1'b1;
          end else if (w_norm_lsh) begin
            r_sig <= {r_sig[SIG_W-2:0], 1'b0};
            r_exp <= r_exp - 1'b1;
          end else begin
            r_result <= {r_sign, r_exp, r_sig[MAN_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FP_SEQ_FLAGS_EN
  logic r_flag_zero, r_flag_ovf, r_flag_unf;

  // Status flags are set with the final NORM action and cleared on leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_zero <= 1'b0;
      r_flag_ovf  <= 1'b0;
      r_flag_unf  <= 1'b0;
    end else if (r_state == ST_DONE && out_ready) begin
      r_flag_zero <= 1'b0;
      r_flag_ovf  <= 1'b0;
      r_flag_unf  <= 1'b0;
    end else if (r_state == ST_NORM && w_norm_done) begin
      r_flag_ovf  <= w_norm_ovf;
      r_flag_zero <= ~w_norm_ovf & (w_norm_zero | w_norm_unf);
      r_flag_unf  <= ~w_norm_ovf & ~w_norm_zero & w_norm_unf;
    end
  end

  assign flag_zero = r_flag_zero;
  assign flag_ovf  = r_flag_ovf;
  assign flag_unf  = r_flag_unf;
`endif

endmodule
